// File: rtl/br_lite_msg_table.sv
// br_lite_msg_table: broadcast message table with duplicate filtering and per-port forwarding
package br_lite_pkg;
  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'd0,
    BR_SVC_CLEAR = 2'd1,
    BR_SVC_TGT   = 2'd2
  } br_svc_t;
  typedef struct packed {
    br_svc_t     svc;
    logic [15:0] source;
    logic [7:0]  id;
    logic [15:0] payload;
  } br_data_t;
  typedef logic [2:0] br_port_t;
  localparam br_port_t EAST  = 3'd0;
  localparam br_port_t WEST  = 3'd1;
  localparam br_port_t NORTH = 3'd2;
  localparam br_port_t SOUTH = 3'd3;
  localparam br_port_t LOCAL = 3'd4;
endpackage

module br_lite_msg_table
  import br_lite_pkg::*;
#(
  parameter int CAM_SIZE = 8,
  parameter int PORT_CNT = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_req_i,
  input  br_data_t            in_data_i,
  input  br_port_t            in_port_i,
  output logic                in_ack_o,
  output logic                in_dup_o,
  output logic                full_o,
  output logic [PORT_CNT-1:0] out_req_o,
  output br_data_t            out_data_o,
  input  logic [PORT_CNT-1:0] out_ack_i
);
  localparam int IW = $clog2(CAM_SIZE);
  typedef enum logic {IDLE, ACK} state_t;
  state_t              state, state_nx;
  logic [CAM_SIZE-1:0] valid, clr;
  br_data_t            data [CAM_SIZE];
  logic [PORT_CNT-1:0] pending [CAM_SIZE];
  logic                locked, dup_q;
  logic [IW-1:0]       lock_idx, hit_idx, free_idx, cand_idx, wr_idx;
  logic                hit, has_free, has_cand, is_clr, act, dup, wr;
  logic [PORT_CNT-1:0] fwd_mask, lock_left;
  // Key lookup, lowest free slot and lowest entry still owing forwards (descending scan keeps the lowest)
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    has_free = 1'b0;
    free_idx = '0;
    has_cand = 1'b0;
    cand_idx = '0;
    for (int i = CAM_SIZE - 1; i >= 0; i--) begin
      if (valid[i] && data[i].source == in_data_i.source && data[i].id == in_data_i.id) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
      if (valid[i] && |pending[i]) begin
        has_cand = 1'b1;
        cand_idx = IW'(i);
      end
    end
  end
  assign is_clr    = in_data_i.svc == BR_SVC_CLEAR;
  assign act       = state == IDLE && in_req_i && (hit || is_clr || has_free);
  assign dup       = hit ? !is_clr : is_clr;
  assign wr        = act && !dup;
  assign wr_idx    = hit ? hit_idx : free_idx;
  assign fwd_mask  = ~(PORT_CNT'(1) << in_port_i);
  assign lock_left = pending[lock_idx] & ~out_ack_i;
  // Insert handshake: any accepted or dropped flit spends exactly one cycle in ACK
  always_comb begin
    state_nx = act ? ACK : IDLE;
  end
  // Table state: forward bookkeeping on the locked entry, then inserts (a rewrite of the locked entry wins over its acks)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      valid    <= '0;
      clr      <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
      dup_q    <= 1'b0;
      for (int i = 0; i < CAM_SIZE; i++) pending[i] <= '0;
    end else begin
      state <= state_nx;
      if (act) dup_q <= dup;
      if (locked && !(wr && wr_idx == lock_idx)) begin
        pending[lock_idx] <= lock_left;
        if (lock_left == '0) begin
          locked <= 1'b0;
          if (clr[lock_idx]) valid[lock_idx] <= 1'b0;
        end
      end else if (!locked && has_cand) begin
        locked   <= 1'b1;
        lock_idx <= cand_idx;
      end
      if (wr) begin
        valid[wr_idx]   <= 1'b1;
        clr[wr_idx]     <= is_clr;
        data[wr_idx]    <= in_data_i;
        pending[wr_idx] <= fwd_mask;
      end
    end
  end
  assign in_ack_o   = state == ACK;
  assign in_dup_o   = state == ACK && dup_q;
  assign full_o     = &valid;
  assign out_req_o  = locked ? pending[lock_idx] : '0;
  assign out_data_o = locked ? data[lock_idx] : '0;
endmodule

// File: tb/tb_br_lite_msg_table.sv
// tb_br_lite_msg_table: vector table, corner sequences and randomized model check of br_lite_msg_table
module tb_br_lite_msg_table;
  import br_lite_pkg::*;
  localparam int CAM = 8;
  localparam int PC = 5;
  logic          clk = 1'b0, rst = 1'b1, in_req = 1'b0;
  logic          in_ack, in_dup, full;
  br_data_t      in_data = '0, out_data;
  br_port_t      in_port = '0;
  logic [PC-1:0] out_req, out_ack = '0;
  int            checks = 0, failures = 0;

  typedef struct {
    br_svc_t       svc;
    logic [15:0]   src;
    logic [7:0]    id;
    br_port_t      port;
    logic          exp_dup;
    logic [PC-1:0] exp_req;
  } vec_t;
  typedef struct {
    logic [15:0] src;
    logic [7:0]  id;
  } key_t;

  vec_t vecs [10];
  key_t model [$];

  always #5 clk = ~clk;

  br_lite_msg_table #(.CAM_SIZE(CAM), .PORT_CNT(PC)) dut (
    .clk_i(clk), .rst_i(rst), .in_req_i(in_req), .in_data_i(in_data), .in_port_i(in_port),
    .in_ack_o(in_ack), .in_dup_o(in_dup), .full_o(full), .out_req_o(out_req),
    .out_data_o(out_data), .out_ack_i(out_ack)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic br_data_t mk(input br_svc_t s, input logic [15:0] src, input logic [7:0] id,
                                  input logic [15:0] pl);
    br_data_t d;
    d.svc = s;
    d.source = src;
    d.id = id;
    d.payload = pl;
    return d;
  endfunction

  function automatic int find(input logic [15:0] src, input logic [7:0] id);
    foreach (model[i]) if (model[i].src == src && model[i].id == id) return i;
    return -1;
  endfunction

  task automatic insert(input br_data_t d, input br_port_t p, output logic dup);
    int n;
    n = 0;
    in_data = d;
    in_port = p;
    in_req = 1'b1;
    do begin
      tick();
      n++;
    end while (!in_ack && n < 20);
    chk("ins_latency", 64'(n), 64'd1);
    dup = in_dup;
    in_req = 1'b0;
  endtask

  task automatic drain(input logic [PC-1:0] exp_mask, input br_data_t exp_data);
    logic [PC-1:0] m;
    int n;
    m = exp_mask;
    n = 0;
    while (out_req == '0 && n < 10) begin
      tick();
      n++;
    end
    chk("fwd_req", 64'(out_req), 64'(exp_mask));
    chk("fwd_data", 64'(out_data), 64'(exp_data));
    for (int k = 0; k < 40 && m != '0; k++) begin
      logic [PC-1:0] a;
      a = PC'($urandom);
      out_ack = a;
      tick();
      out_ack = '0;
      m &= ~a;
      chk("fwd_ack_step", 64'(out_req), 64'(m));
    end
    chk("fwd_done", 64'(out_req), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model.delete();
  endtask

  initial begin
    br_data_t d;
    logic     dv;
    vecs[0] = '{BR_SVC_ALL,   16'h0102, 8'd3, WEST,  1'b0, 5'b11101};
    vecs[1] = '{BR_SVC_ALL,   16'h0102, 8'd3, NORTH, 1'b1, 5'b00000};
    vecs[2] = '{BR_SVC_CLEAR, 16'h0102, 8'd3, EAST,  1'b0, 5'b11110};
    vecs[3] = '{BR_SVC_ALL,   16'h0102, 8'd3, SOUTH, 1'b0, 5'b10111};
    vecs[4] = '{BR_SVC_CLEAR, 16'h0300, 8'd7, LOCAL, 1'b1, 5'b00000};
    vecs[5] = '{BR_SVC_TGT,   16'h0300, 8'd7, LOCAL, 1'b0, 5'b01111};
    vecs[6] = '{BR_SVC_TGT,   16'h0300, 8'd7, EAST,  1'b1, 5'b00000};
    vecs[7] = '{BR_SVC_CLEAR, 16'h0300, 8'd7, LOCAL, 1'b0, 5'b01111};
    vecs[8] = '{BR_SVC_CLEAR, 16'h0300, 8'd7, LOCAL, 1'b1, 5'b00000};
    vecs[9] = '{BR_SVC_ALL,   16'h0102, 8'd3, WEST,  1'b1, 5'b00000};

    do_reset();
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ack", 64'(in_ack), 64'd0);
    chk("rst_dup", 64'(in_dup), 64'd0);

    foreach (vecs[i]) begin
      d = mk(vecs[i].svc, vecs[i].src, vecs[i].id, 16'($urandom));
      insert(d, vecs[i].port, dv);
      chk("vec_dup", 64'(dv), 64'(vecs[i].exp_dup));
      if (vecs[i].exp_req != '0) drain(vecs[i].exp_req, d);
      else begin
        tick();
        tick();
        chk("vec_no_fwd", 64'(out_req), 64'd0);
      end
      chk("vec_full", 64'(full), 64'd0);
    end

    d = mk(BR_SVC_ALL, 16'h0500, 8'd1, 16'h1111);
    insert(d, WEST, dv);
    chk("lk_dup", 64'(dv), 64'd0);
    tick();
    chk("lk_req", 64'(out_req), 64'b11101);
    out_ack = 5'b00001;
    tick();
    out_ack = '0;
    chk("lk_partial", 64'(out_req), 64'b11100);
    d = mk(BR_SVC_CLEAR, 16'h0500, 8'd1, 16'h2222);
    in_data = d;
    in_port = NORTH;
    in_req = 1'b1;
    out_ack = 5'b11111;
    tick();
    out_ack = '0;
    chk("lk_ack", 64'(in_ack), 64'd1);
    chk("lk_rewrite_req", 64'(out_req), 64'b11011);
    chk("lk_rewrite_data", 64'(out_data), 64'(d));
    in_req = 1'b0;
    drain(5'b11011, d);
    d = mk(BR_SVC_ALL, 16'h0500, 8'd1, 16'h3333);
    insert(d, EAST, dv);
    chk("lk_reinsert_dup", 64'(dv), 64'd0);
    drain(5'b11110, d);

    do_reset();
    for (int i = 0; i < CAM; i++) begin
      chk("fill_full_before", 64'(full), 64'd0);
      d = mk(BR_SVC_ALL, 16'h0400, 8'(i), 16'($urandom));
      insert(d, LOCAL, dv);
      chk("fill_dup", 64'(dv), 64'd0);
      drain(5'b01111, d);
    end
    chk("fill_full", 64'(full), 64'd1);
    d = mk(BR_SVC_CLEAR, 16'h0400, 8'd2, 16'h4444);
    insert(d, LOCAL, dv);
    chk("fill_clr_dup", 64'(dv), 64'd0);
    tick();
    chk("fill_clr_req", 64'(out_req), 64'b01111);
    d = mk(BR_SVC_ALL, 16'h0400, 8'd8, 16'h5555);
    in_data = d;
    in_port = WEST;
    in_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_no_ack", 64'(in_ack), 64'd0);
      chk("stall_full", 64'(full), 64'd1);
    end
    out_ack = 5'b01111;
    tick();
    out_ack = '0;
    chk("free_full", 64'(full), 64'd0);
    chk("free_no_ack_yet", 64'(in_ack), 64'd0);
    tick();
    chk("ninth_ack", 64'(in_ack), 64'd1);
    chk("ninth_dup", 64'(in_dup), 64'd0);
    in_req = 1'b0;
    drain(5'b11101, d);
    chk("ninth_full", 64'(full), 64'd1);

    do_reset();
    d = mk(BR_SVC_ALL, 16'h0600, 8'd9, 16'h6666);
    insert(d, NORTH, dv);
    chk("rm_dup", 64'(dv), 64'd0);
    tick();
    out_ack = 5'b11000;
    tick();
    out_ack = '0;
    chk("rm_req", 64'(out_req), 64'b00011);
    rst = 1'b1;
    tick();
    chk("rm_out_req", 64'(out_req), 64'd0);
    chk("rm_out_data", 64'(out_data), 64'd0);
    chk("rm_full", 64'(full), 64'd0);
    chk("rm_ack", 64'(in_ack), 64'd0);
    rst = 1'b0;
    insert(d, NORTH, dv);
    chk("rm_reinsert_dup", 64'(dv), 64'd0);
    drain(5'b11011, d);

    do_reset();
    for (int it = 0; it < 120; it++) begin
      logic [15:0] src;
      logic [7:0]  id;
      br_svc_t     svc;
      br_port_t    port;
      int          idx, r;
      logic        exp_dup;
      src = 16'h0700 + 16'($urandom_range(0, 1));
      id = 8'($urandom_range(0, 5));
      r = $urandom_range(0, 3);
      svc = r == 0 ? BR_SVC_CLEAR : r == 1 ? BR_SVC_TGT : BR_SVC_ALL;
      idx = find(src, id);
      if (idx < 0 && svc != BR_SVC_CLEAR && model.size() == CAM) begin
        idx = $urandom_range(0, CAM - 1);
        src = model[idx].src;
        id = model[idx].id;
        svc = BR_SVC_CLEAR;
      end
      port = br_port_t'($urandom_range(0, PC - 1));
      d = mk(svc, src, id, 16'($urandom));
      exp_dup = idx >= 0 ? svc != BR_SVC_CLEAR : svc == BR_SVC_CLEAR;
      insert(d, port, dv);
      chk("rnd_dup", 64'(dv), 64'(exp_dup));
      if (!exp_dup) begin
        drain(~(PC'(1) << port), d);
        if (svc == BR_SVC_CLEAR) model.delete(idx);
        else model.push_back('{src, id});
      end else begin
        tick();
        tick();
        chk("rnd_no_fwd", 64'(out_req), 64'd0);
      end
      chk("rnd_full", 64'(full), 64'(model.size() == CAM));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
